lfsr_bank: RTL and testbench



---
 rtl/lfsr_bank.sv | 173 +++++++++++++++++
 tb/tb_lfsr_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bank.sv
// -----------------------------------------------------------------------------
// lfsr_bank
//
// Bank of CHANNELS independent Galois (right-shift) LFSRs. Each channel has
// its own tap (polynomial) register, state register and step counter. Taps and
// states are written through one shared write port. A channel can be started
// on an autonomous run of start_cnt steps. Any channel can be read
// combinationally through rd_ch.
//
// Ports
//   clk        in   1         clock, rising edge
//   reset      in   1         synchronous active-high reset
//   wr_e       in   1         write enable
//   wr_tap     in   1         1 = write tap register, 0 = write state register
//   wr_ch      in   CW        write channel
//   wd         in   WIDTH     write data
//   start_e    in   1         start a stepping run
//   start_ch   in   CW        channel to start
//   start_cnt  in   CNTW      number of steps (0 = ignored)
//   rd_ch      in   CW        read channel
//   rd_tap     out  WIDTH     tap of rd_ch
//   rd_state   out  WIDTH     state of rd_ch
//   rd_lock    out  1         rd_state is all-zero (lock-up)
//   busy       out  CHANNELS  per-channel run in progress
//   done       out  CHANNELS  per-channel one-cycle run-complete pulse
// -----------------------------------------------------------------------------
module lfsr_bank #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 4,
    parameter int               CW           = $clog2(CHANNELS),
    parameter int               CNTW         = 16,
    parameter logic [WIDTH-1:0] TAP_DEFAULT  = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(32'd1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_e,
    input  logic                wr_tap,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wd,
    input  logic                start_e,
    input  logic [CW-1:0]       start_ch,
    input  logic [CNTW-1:0]     start_cnt,
    input  logic [CW-1:0]       rd_ch,
    output logic [WIDTH-1:0]    rd_tap,
    output logic [WIDTH-1:0]    rd_state,
    output logic                rd_lock,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    fsm_e                r_fsm       [CHANNELS];
    fsm_e                w_fsm_nxt   [CHANNELS];
    logic [WIDTH-1:0]    r_tap       [CHANNELS];
    logic [WIDTH-1:0]    w_tap_nxt   [CHANNELS];
    logic [WIDTH-1:0]    r_state     [CHANNELS];
    logic [WIDTH-1:0]    w_state_nxt [CHANNELS];
    logic [CNTW-1:0]     r_cnt       [CHANNELS];
    logic [CNTW-1:0]     w_cnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0] r_done;
    logic [CHANNELS-1:0] w_done_nxt;
    logic [CHANNELS-1:0] w_busy;
    logic [WIDTH-1:0]    w_rd_tap;
    logic [WIDTH-1:0]    w_rd_state;

    // One Galois step: shift right, fold the tap in when a 1 falls out.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] t
    );
        return (s >> 1) ^ (s[0] ? t : {WIDTH{1'b0}});
    endfunction

    // Per-channel next-state: run FSM, step counter, and write-port merge.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_fsm_nxt[c]   = r_fsm[c];
            w_cnt_nxt[c]   = r_cnt[c];
            w_tap_nxt[c]   = r_tap[c];
            w_state_nxt[c] = r_state[c];
            w_done_nxt[c]  = 1'b0;
            w_busy[c]      = 1'b0;

            case (r_fsm[c])
                ST_IDLE: begin
                    // Accept edge only loads the count; stepping starts next edge.
                    if (start_e && (start_ch == CW'(c)) && (start_cnt != {CNTW{1'b0}})) begin
                        w_fsm_nxt[c] = ST_RUN;
                        w_cnt_nxt[c] = start_cnt;
                    end else begin
                        w_fsm_nxt[c] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Starts aimed at a running channel are not looked at here.
                    w_busy[c]      = 1'b1;
                    w_state_nxt[c] = f_step(r_state[c], r_tap[c]);
                    w_cnt_nxt[c]   = r_cnt[c] - CNTW'(1);
                    if (r_cnt[c] == CNTW'(1)) begin
                        w_fsm_nxt[c]  = ST_IDLE;
                        w_done_nxt[c] = 1'b1;
                    end else begin
                        w_fsm_nxt[c] = ST_RUN;
                    end
                end
                default: begin
                    w_fsm_nxt[c] = ST_IDLE;
                end
            endcase

            // A state write overrides the step result but the step is still
            // counted; a tap write only affects steps after this edge because
            // the step above already used the old r_tap.
            if (wr_e && (wr_ch == CW'(c))) begin
                if (wr_tap) begin
                    w_tap_nxt[c] = wd;
                end else begin
                    w_state_nxt[c] = wd;
                end
            end else begin
                w_tap_nxt[c] = w_tap_nxt[c];
            end
        end
    end

    // Register bank: FSM, counters, taps, states and done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_fsm[c]   <= ST_IDLE;
                r_cnt[c]   <= {CNTW{1'b0}};
                r_tap[c]   <= TAP_DEFAULT;
                r_state[c] <= SEED_DEFAULT;
            end
            r_done <= {CHANNELS{1'b0}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_fsm[c]   <= w_fsm_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
                r_tap[c]   <= w_tap_nxt[c];
                r_state[c] <= w_state_nxt[c];
            end
            r_done <= w_done_nxt;
        end
    end

    // Read mux; a non-existent channel number reads as zero.
    always_comb begin
        w_rd_tap   = {WIDTH{1'b0}};
        w_rd_state = {WIDTH{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CW'(c)) begin
                w_rd_tap   = r_tap[c];
                w_rd_state = r_state[c];
            end else begin
                w_rd_tap   = w_rd_tap;
                w_rd_state = w_rd_state;
            end
        end
    end

    assign rd_tap   = w_rd_tap;
    assign rd_state = w_rd_state;
    assign rd_lock  = (w_rd_state == {WIDTH{1'b0}});
    assign busy     = w_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_lfsr_bank.sv
// -----------------------------------------------------------------------------
// tb_lfsr_bank
//
// Bench for lfsr_bank at WIDTH=8, TAP_DEFAULT=8'hB8. A behavioural model keeps
// per-channel tap, state and "steps remaining"; a compare process checks all
// outputs against it on every falling edge. Directed scenarios pin the model
// with hand-computed values, then a randomized phase exercises everything.
// -----------------------------------------------------------------------------
module tb_lfsr_bank;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int CW   = 2;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_e;
    logic            wr_tap;
    logic [CW-1:0]   wr_ch;
    logic [W-1:0]    wd;
    logic            start_e;
    logic [CW-1:0]   start_ch;
    logic [CNTW-1:0] start_cnt;
    logic [CW-1:0]   rd_ch;
    logic [W-1:0]    rd_tap;
    logic [W-1:0]    rd_state;
    logic            rd_lock;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;

    always #5 clk = ~clk;

    lfsr_bank #(
        .WIDTH       (W),
        .CHANNELS    (CH),
        .CW          (CW),
        .CNTW        (CNTW),
        .TAP_DEFAULT (8'hB8),
        .SEED_DEFAULT(8'h01)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_e     (wr_e),
        .wr_tap   (wr_tap),
        .wr_ch    (wr_ch),
        .wd       (wd),
        .start_e  (start_e),
        .start_ch (start_ch),
        .start_cnt(start_cnt),
        .rd_ch    (rd_ch),
        .rd_tap   (rd_tap),
        .rd_state (rd_state),
        .rd_lock  (rd_lock),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Behavioural model
    logic [W-1:0]  m_tap   [CH];
    logic [W-1:0]  m_state [CH];
    int            m_rem   [CH];
    logic [CH-1:0] m_done;
    logic [CH-1:0] m_busy;
    logic [W-1:0]  m_ns;

    logic [W-1:0]  exp3 [3] = '{8'hB8, 8'h5C, 8'h2E};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gal(input logic [W-1:0] s, input logic [W-1:0] t);
        return (s >> 1) ^ (s[0] ? t : 8'h00);
    endfunction

    // Model update from the inputs present at each rising edge.
    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                m_tap[c]   = 8'hB8;
                m_state[c] = 8'h01;
                m_rem[c]   = 0;
                m_done[c]  = 1'b0;
            end else begin
                m_done[c] = 1'b0;
                m_ns      = m_state[c];
                if (m_rem[c] != 0) begin
                    m_ns     = gal(m_state[c], m_tap[c]);
                    m_rem[c] = m_rem[c] - 1;
                    if (m_rem[c] == 0) m_done[c] = 1'b1;
                end else if (start_e && int'(start_ch) == c && start_cnt != 16'd0) begin
                    m_rem[c] = int'(start_cnt);
                end
                if (wr_e && int'(wr_ch) == c) begin
                    if (wr_tap) m_tap[c] = wd;
                    else        m_ns     = wd;
                end
                m_state[c] = m_ns;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < CH; c++) m_busy[c] = (m_rem[c] != 0);
            chk("busy",     32'(busy),     32'(m_busy));
            chk("done",     32'(done),     32'(m_done));
            chk("rd_tap",   32'(rd_tap),   32'(m_tap[rd_ch]));
            chk("rd_state", 32'(rd_state), 32'(m_state[rd_ch]));
            chk("rd_lock",  32'(rd_lock),  32'(m_state[rd_ch] == 8'h00));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_e    = 1'b0;
        start_e = 1'b0;
    endtask

    task automatic wr(input logic tap, input logic [CW-1:0] ch, input logic [W-1:0] d);
        wr_e = 1'b1; wr_tap = tap; wr_ch = ch; wd = d;
        tick();
    endtask

    task automatic start(input logic [CW-1:0] ch, input logic [CNTW-1:0] cnt);
        start_e = 1'b1; start_ch = ch; start_cnt = cnt;
        tick();
    endtask

    initial begin
        int nb, n_tick, d0, d2;
        bit seen01, got_done, s3, nd;

        reset = 1'b1; wr_e = 1'b0; wr_tap = 1'b0; wr_ch = '0; wd = '0;
        start_e = 1'b0; start_ch = '0; start_cnt = '0; rd_ch = '0;
        tick();
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset values on every channel
        for (int c = 0; c < CH; c++) begin
            rd_ch = CW'(c);
            #1;
            chk("rst_tap",   32'(rd_tap),   32'(8'hB8));
            chk("rst_state", 32'(rd_state), 32'(8'h01));
        end
        chk("rst_busy", 32'(busy), 32'(4'h0));
        chk("rst_done", 32'(done), 32'(4'h0));

        // Three-step run on ch1; busy spans the cycles between E0 and E3
        wr(1'b1, 2'd1, 8'hB8);
        wr(1'b0, 2'd1, 8'h01);
        rd_ch = 2'd1;
        start(2'd1, 16'd3);
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy[1]) nb++;
            tick();
            chk("run3_state", 32'(rd_state), 32'(exp3[i]));
        end
        chk("run3_busycyc", 32'(nb), 32'd3);
        chk("run3_busy_end", 32'(busy[1]), 32'd0);
        chk("run3_done", 32'(done[1]), 32'd1);
        tick();
        chk("run3_done_1cyc", 32'(done[1]), 32'd0);

        // Full period of 8'hB8
        wr(1'b0, 2'd1, 8'h01);
        start(2'd1, 16'd255);
        n_tick = 0; seen01 = 1'b0; got_done = 1'b0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            tick();
            n_tick++;
            if (done[1]) got_done = 1'b1;
            else if (rd_state == 8'h01) seen01 = 1'b1;
        end
        chk("period_done", 32'(got_done), 32'd1);
        chk("period_len", 32'(n_tick), 32'd255);
        chk("period_no_early_01", 32'(seen01), 32'd0);
        chk("period_final", 32'(rd_state), 32'(8'h01));

        // Concurrency, restart while busy, zero count
        d0 = 0; d2 = 0; s3 = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            case (e)
                1: begin start_e = 1'b1; start_ch = 2'd0; start_cnt = 16'd5; end
                2: begin start_e = 1'b1; start_ch = 2'd2; start_cnt = 16'd2; end
                3: begin start_e = 1'b1; start_ch = 2'd0; start_cnt = 16'd9; end
                4: begin start_e = 1'b1; start_ch = 2'd3; start_cnt = 16'd0; end
                default: start_e = 1'b0;
            endcase
            tick();
            if (done[0] && d0 == 0) d0 = e;
            if (done[2] && d2 == 0) d2 = e;
            if (busy[3] || done[3]) s3 = 1'b1;
        end
        chk("conc_done0_edge", 32'(d0), 32'd6);
        chk("conc_done2_edge", 32'(d2), 32'd4);
        chk("cnt0_ignored", 32'(s3), 32'd0);

        // State write during a step: write wins, step still consumed
        wr(1'b0, 2'd1, 8'h01);
        rd_ch = 2'd1;
        start(2'd1, 16'd4);
        tick();
        chk("sw_e1", 32'(rd_state), 32'(8'hB8));
        wr(1'b0, 2'd1, 8'h10);
        chk("sw_e2", 32'(rd_state), 32'(8'h10));
        tick();
        chk("sw_e3", 32'(rd_state), 32'(8'h08));
        tick();
        chk("sw_e4", 32'(rd_state), 32'(8'h04));
        chk("sw_done", 32'(done[1]), 32'd1);

        // Tap write during a step: that step uses the old tap
        wr(1'b1, 2'd2, 8'hB8);
        wr(1'b0, 2'd2, 8'h03);
        rd_ch = 2'd2;
        start(2'd2, 16'd2);
        wr(1'b1, 2'd2, 8'h8E);
        chk("tw_e1_state", 32'(rd_state), 32'(8'hB9));
        chk("tw_e1_tap", 32'(rd_tap), 32'(8'h8E));
        tick();
        chk("tw_e2_state", 32'(rd_state), 32'(8'hD2));
        chk("tw_done", 32'(done[2]), 32'd1);

        // Zero seed locks up
        wr(1'b0, 2'd3, 8'h00);
        rd_ch = 2'd3;
        start(2'd3, 16'd3);
        tick(); tick(); tick();
        chk("zero_state", 32'(rd_state), 32'd0);
        chk("zero_lock", 32'(rd_lock), 32'd1);
        chk("zero_done", 32'(done[3]), 32'd1);

        // Reset mid-run abandons the run silently
        wr(1'b0, 2'd0, 8'h55);
        rd_ch = 2'd0;
        start(2'd0, 16'd10);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_state", 32'(rd_state), 32'(8'h01));
        nd = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done != 4'h0) nd = 1'b1;
        end
        chk("mr_no_done", 32'(nd), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            wr_e      = ($urandom_range(0, 3) == 0);
            wr_tap    = 1'($urandom);
            wr_ch     = CW'($urandom);
            wd        = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            start_e   = ($urandom_range(0, 2) == 0);
            start_ch  = CW'($urandom);
            start_cnt = CNTW'($urandom_range(0, 12));
            rd_ch     = CW'($urandom);
            tick();
        end
        reset = 1'b0;
        tick();
        tick();
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
